// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Holds the parameter defaults, the read-port selection type and a ceil-log2 helper.
package reg_file_sb_pkg;

   localparam int RF_WIDTH    = 32;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_ADDR_LEN = 5;
   localparam int RF_NUM_RD   = 2;

   typedef enum logic [2:0] {
      RD_IDLE   = 3'd0,
      RD_ZERO   = 3'd1,
      RD_BYPASS = 3'd2,
      RD_REG    = 3'd3,
      RD_STALL  = 3'd4
   } rd_sel_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((32'sd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: priority select (zero, forward, stored, stall) and its output registers.
// The pending bit seen here is the pre-edge value, so same-edge reservations never stall this read.
module reg_file_rd_port
   import reg_file_sb_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int ADDR_LEN = RF_ADDR_LEN,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   input  logic [ADDR_LEN-1:0] addr,
   input  logic                pend,
   input  logic [WIDTH-1:0]    reg_data,
   input  logic                wr_en,
   input  logic [ADDR_LEN-1:0] wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [WIDTH-1:0]    data,
   output logic                valid,
   output logic                stall
);

   rd_sel_e          sel_s;
   logic [WIDTH-1:0] data_r, data_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic             stall_r, stall_nxt_s;

   // Pick the source for this request in priority order.
   always_comb begin
      if (!req) begin
         sel_s = RD_IDLE;
      end else if (addr == {ADDR_LEN{1'b0}}) begin
         sel_s = RD_ZERO;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
         sel_s = RD_BYPASS;
      end else if (!pend) begin
         sel_s = RD_REG;
      end else begin
         sel_s = RD_STALL;
      end
   end

   // Next output values; data holds unless the request is served.
   always_comb begin
      data_nxt_s  = data_r;
      valid_nxt_s = 1'b0;
      stall_nxt_s = 1'b0;
      case (sel_s)
         RD_ZERO: begin
            data_nxt_s  = {WIDTH{1'b0}};
            valid_nxt_s = 1'b1;
         end
         RD_BYPASS: begin
            data_nxt_s  = wr_data;
            valid_nxt_s = 1'b1;
         end
         RD_REG: begin
            data_nxt_s  = reg_data;
            valid_nxt_s = 1'b1;
         end
         RD_STALL: begin
            stall_nxt_s = 1'b1;
         end
         default: begin
            data_nxt_s  = data_r;
            valid_nxt_s = 1'b0;
            stall_nxt_s = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         stall_r <= 1'b0;
      end else begin
         data_r  <= data_nxt_s;
         valid_r <= valid_nxt_s;
         stall_r <= stall_nxt_s;
      end
   end

   assign data  = data_r;
   assign valid = valid_r;
   assign stall = stall_r;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD registered read ports, one write port and a pending-write scoreboard.
// Register 0 reads as zero and is never written or reserved.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_LEN = RF_ADDR_LEN,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD-1:0]          rd_req,
   input  logic [NUM_RD*ADDR_LEN-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic [NUM_RD-1:0]          rd_stall,
   input  logic                       rsv_en,
   input  logic [ADDR_LEN-1:0]        rsv_addr,
   input  logic                       wr_en,
   input  logic [ADDR_LEN-1:0]        wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [ADDR_LEN:0]          pend_cnt,
   output logic                       sb_err
);

   logic [WIDTH-1:0]    regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] pend_nxt_s;
   logic [ADDR_LEN:0]   pend_cnt_r, pend_cnt_nxt_s;
   logic                sb_err_r, sb_err_nxt_s;
   logic                wr_hit_s, rsv_hit_s;

   assign wr_hit_s  = wr_en  && (wr_addr  != {ADDR_LEN{1'b0}});
   assign rsv_hit_s = rsv_en && (rsv_addr != {ADDR_LEN{1'b0}});

   // Scoreboard update: a reservation outranks a retiring write to the same register.
   always_comb begin
      pend_nxt_s     = pending_r;
      pend_cnt_nxt_s = {(ADDR_LEN+1){1'b0}};
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rsv_hit_s && (rsv_addr == r[ADDR_LEN-1:0])) begin
            pend_nxt_s[r] = 1'b1;
         end else if (wr_hit_s && (wr_addr == r[ADDR_LEN-1:0])) begin
            pend_nxt_s[r] = 1'b0;
         end else begin
            pend_nxt_s[r] = pending_r[r];
         end
         pend_cnt_nxt_s = pend_cnt_nxt_s + {{ADDR_LEN{1'b0}}, pend_nxt_s[r]};
      end
      sb_err_nxt_s = rsv_hit_s && pending_r[rsv_addr] && !(wr_hit_s && (wr_addr == rsv_addr));
   end

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_r[r] <= {WIDTH{1'b0}};
         end
      end else if (wr_hit_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   // Scoreboard state, pending count and double-reserve flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r  <= {NUM_REGS{1'b0}};
         pend_cnt_r <= {(ADDR_LEN+1){1'b0}};
         sb_err_r   <= 1'b0;
      end else begin
         pending_r  <= pend_nxt_s;
         pend_cnt_r <= pend_cnt_nxt_s;
         sb_err_r   <= sb_err_nxt_s;
      end
   end

   assign pend_cnt = pend_cnt_r;
   assign sb_err   = sb_err_r;

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_LEN-1:0] addr_s;
      assign addr_s = rd_addr[g*ADDR_LEN +: ADDR_LEN];

      reg_file_rd_port #(
         .WIDTH    (WIDTH),
         .ADDR_LEN (ADDR_LEN),
         .BYPASS   (BYPASS)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .req      (rd_req[g]),
         .addr     (addr_s),
         .pend     (pending_r[addr_s]),
         .reg_data (regs_r[addr_s]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .data     (rd_data[g*WIDTH +: WIDTH]),
         .valid    (rd_valid[g]),
         .stall    (rd_stall[g])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a forwarding and a non-forwarding 2-port instance share
// stimulus; a 4-port instance covers mixed served/stalled ports in one cycle.
module tb_reg_file_sb;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  rd_req;
   logic [9:0]  rd_addr;
   logic        rsv_en, wr_en;
   logic [4:0]  rsv_addr, wr_addr;
   logic [31:0] wr_data;

   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_valid_a, rd_valid_b, rd_stall_a, rd_stall_b;
   logic [5:0]  pend_cnt_a, pend_cnt_b;
   logic        sb_err_a, sb_err_b;

   logic [3:0]   rd_req4;
   logic [19:0]  rd_addr4;
   logic         rsv_en4, wr_en4;
   logic [4:0]   rsv_addr4, wr_addr4;
   logic [31:0]  wr_data4;
   logic [127:0] rd_data_4;
   logic [3:0]   rd_valid_4, rd_stall_4;
   logic [5:0]   pend_cnt_4;
   logic         sb_err_4;

   int errors = 0;
   int checks = 0;

   reg_file_sb #(.NUM_RD(2), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_stall(rd_stall_a),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .pend_cnt(pend_cnt_a), .sb_err(sb_err_a));

   reg_file_sb #(.NUM_RD(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_stall(rd_stall_b),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .pend_cnt(pend_cnt_b), .sb_err(sb_err_b));

   reg_file_sb #(.NUM_RD(4), .BYPASS(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req4), .rd_addr(rd_addr4),
      .rd_data(rd_data_4), .rd_valid(rd_valid_4), .rd_stall(rd_stall_4),
      .rsv_en(rsv_en4), .rsv_addr(rsv_addr4), .wr_en(wr_en4), .wr_addr(wr_addr4),
      .wr_data(wr_data4), .pend_cnt(pend_cnt_4), .sb_err(sb_err_4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_req = 2'b00; rd_addr = 10'd0;
      rsv_en = 1'b0; rsv_addr = 5'd0;
      wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      rd_req4 = 4'b0000; rd_addr4 = 20'd0;
      rsv_en4 = 1'b0; rsv_addr4 = 5'd0;
      wr_en4 = 1'b0; wr_addr4 = 5'd0; wr_data4 = 32'd0;
   endtask

   task automatic test_reset();
      idle();
      #1 rst_n = 1'b0;
      #10;
      checks++;
      if ({rd_data_a, rd_valid_a, rd_stall_a, pend_cnt_a, sb_err_a} !== 75'd0) begin
         errors++; $display("FAIL reset_a: got data=%h v=%b s=%b cnt=%0d err=%b want all 0",
                            rd_data_a, rd_valid_a, rd_stall_a, pend_cnt_a, sb_err_a);
      end
      checks++;
      if ({rd_data_4, rd_valid_4, rd_stall_4, pend_cnt_4, sb_err_4} !== 143'd0) begin
         errors++; $display("FAIL reset_4: got data=%h v=%b s=%b want all 0",
                            rd_data_4, rd_valid_4, rd_stall_4);
      end
      @(negedge clk) rst_n = 1'b1;
      rd_req = 2'b11; rd_addr = {5'd5, 5'd5};
      step();
      checks++;
      if (rd_valid_a !== 2'b11 || rd_data_a !== 64'd0 || pend_cnt_a !== 6'd0) begin
         errors++; $display("FAIL read_after_reset: got v=%b data=%h cnt=%0d want v=11 data=0 cnt=0",
                            rd_valid_a, rd_data_a, pend_cnt_a);
      end
      idle();
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
      step();
      checks++;
      if (sb_err_a !== 1'b0 || pend_cnt_a !== 6'd0) begin
         errors++; $display("FAIL write_nonpending: got err=%b cnt=%0d want 0 0", sb_err_a, pend_cnt_a);
      end
      idle();
      rd_req = 2'b01; rd_addr = {5'd0, 5'd3};
      step();
      checks++;
      if (rd_valid_a[0] !== 1'b1 || rd_data_a[31:0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL read_r3: got v=%b data=%h want 1 deadbeef", rd_valid_a[0], rd_data_a[31:0]);
      end
      idle();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h00001234;
      step();
      idle();
      rd_req = 2'b01; rd_addr = 10'd0;
      step();
      checks++;
      if (rd_valid_a[0] !== 1'b1 || rd_data_a[31:0] !== 32'd0) begin
         errors++; $display("FAIL read_r0: got v=%b data=%h want 1 0", rd_valid_a[0], rd_data_a[31:0]);
      end
      idle();
   endtask

   task automatic test_stall_bypass();
      rsv_en = 1'b1; rsv_addr = 5'd7;
      step();
      checks++;
      if (pend_cnt_a !== 6'd1 || pend_cnt_b !== 6'd1) begin
         errors++; $display("FAIL rsv_r7_cnt: got %0d/%0d want 1", pend_cnt_a, pend_cnt_b);
      end
      idle();
      rd_req = 2'b10; rd_addr = {5'd7, 5'd0};
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (rd_stall_a[1] !== 1'b1 || rd_valid_a[1] !== 1'b0 ||
             rd_stall_b[1] !== 1'b1 || rd_valid_b[1] !== 1'b0) begin
            errors++; $display("FAIL stall_r7 cyc%0d: got a s=%b v=%b b s=%b v=%b want s=1 v=0",
                               c, rd_stall_a[1], rd_valid_a[1], rd_stall_b[1], rd_valid_b[1]);
         end
      end
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
      step();
      checks++;
      if (rd_valid_a[1] !== 1'b1 || rd_stall_a[1] !== 1'b0 || rd_data_a[63:32] !== 32'hA5A5A5A5 ||
          pend_cnt_a !== 6'd0) begin
         errors++; $display("FAIL bypass_r7: got v=%b s=%b data=%h cnt=%0d want 1 0 a5a5a5a5 0",
                            rd_valid_a[1], rd_stall_a[1], rd_data_a[63:32], pend_cnt_a);
      end
      checks++;
      if (rd_valid_b[1] !== 1'b0 || rd_stall_b[1] !== 1'b1 || pend_cnt_b !== 6'd0) begin
         errors++; $display("FAIL nobypass_r7: got v=%b s=%b cnt=%0d want 0 1 0",
                            rd_valid_b[1], rd_stall_b[1], pend_cnt_b);
      end
      wr_en = 1'b0;
      step();
      checks++;
      if (rd_valid_b[1] !== 1'b1 || rd_data_b[63:32] !== 32'hA5A5A5A5 ||
          rd_valid_a[1] !== 1'b1 || rd_data_a[63:32] !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL after_write_r7: got b v=%b data=%h a v=%b data=%h want 1 a5a5a5a5",
                            rd_valid_b[1], rd_data_b[63:32], rd_valid_a[1], rd_data_a[63:32]);
      end
      idle();
   endtask

   task automatic test_wr_rsv_same();
      rsv_en = 1'b1; rsv_addr = 5'd9;
      step();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
      step();
      checks++;
      if (sb_err_a !== 1'b0 || pend_cnt_a !== 6'd1) begin
         errors++; $display("FAIL wr_rsv_same: got err=%b cnt=%0d want 0 1", sb_err_a, pend_cnt_a);
      end
      wr_en = 1'b0;
      step();
      checks++;
      if (sb_err_a !== 1'b1 || pend_cnt_a !== 6'd1) begin
         errors++; $display("FAIL double_rsv: got err=%b cnt=%0d want 1 1", sb_err_a, pend_cnt_a);
      end
      idle();
      rd_req = 2'b01; rd_addr = {5'd0, 5'd9};
      step();
      checks++;
      if (sb_err_a !== 1'b0 || rd_stall_a[0] !== 1'b1) begin
         errors++; $display("FAIL err_pulse_r9_pend: got err=%b stall=%b want 0 1", sb_err_a, rd_stall_a[0]);
      end
      idle();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
      step();
      idle();
   endtask

   task automatic test_rsv_same_cycle();
      rd_req = 2'b01; rd_addr = {5'd0, 5'd10};
      rsv_en = 1'b1; rsv_addr = 5'd10;
      step();
      checks++;
      if (rd_valid_a[0] !== 1'b1 || rd_stall_a[0] !== 1'b0 || rd_data_a[31:0] !== 32'd0) begin
         errors++; $display("FAIL rsv_same_edge_read: got v=%b s=%b data=%h want 1 0 0",
                            rd_valid_a[0], rd_stall_a[0], rd_data_a[31:0]);
      end
      rsv_en = 1'b0;
      step();
      checks++;
      if (rd_valid_a[0] !== 1'b0 || rd_stall_a[0] !== 1'b1) begin
         errors++; $display("FAIL rsv_next_read: got v=%b s=%b want 0 1", rd_valid_a[0], rd_stall_a[0]);
      end
      idle();
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0;
      step();
      idle();
   endtask

   task automatic test_back_to_back_reset();
      for (int k = 0; k < 3; k++) begin
         rsv_en = 1'b1; rsv_addr = 5'(4 + k);
         step();
         checks++;
         if (pend_cnt_a !== 6'(k + 1)) begin
            errors++; $display("FAIL rsv_b2b_cnt%0d: got %0d want %0d", k, pend_cnt_a, k + 1);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rd_data_a, rd_valid_a, rd_stall_a, pend_cnt_a, sb_err_a} !== 75'd0 ||
          {rd_data_b, pend_cnt_b} !== 70'd0) begin
         errors++; $display("FAIL mid_reset: got data=%h v=%b cnt=%0d b data=%h want all 0",
                            rd_data_a, rd_valid_a, pend_cnt_a, rd_data_b);
      end
      idle();
      @(negedge clk) rst_n = 1'b1;
      rd_req = 2'b11; rd_addr = {5'd3, 5'd4};
      step();
      checks++;
      if (rd_valid_a !== 2'b11 || rd_stall_a !== 2'b00 || rd_data_a !== 64'd0) begin
         errors++; $display("FAIL read_after_mid_reset: got v=%b s=%b data=%h want 11 00 0",
                            rd_valid_a, rd_stall_a, rd_data_a);
      end
      idle();
   endtask

   task automatic test_multi_port();
      wr_en4 = 1'b1; wr_addr4 = 5'd2; wr_data4 = 32'h55;
      step();
      wr_en4 = 1'b0;
      rsv_en4 = 1'b1; rsv_addr4 = 5'd8;
      step();
      rsv_en4 = 1'b0;
      rd_req4 = 4'b1111; rd_addr4 = {5'd8, 5'd2, 5'd2, 5'd2};
      step();
      checks++;
      if (rd_valid_4 !== 4'b0111 || rd_stall_4 !== 4'b1000 || pend_cnt_4 !== 6'd1) begin
         errors++; $display("FAIL multi_port_flags: got v=%b s=%b cnt=%0d want 0111 1000 1",
                            rd_valid_4, rd_stall_4, pend_cnt_4);
      end
      checks++;
      if (rd_data_4[95:0] !== {32'h55, 32'h55, 32'h55}) begin
         errors++; $display("FAIL multi_port_data: got %h want 000000550000005500000055", rd_data_4[95:0]);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_stall_bypass();
      test_wr_rsv_same();
      test_rsv_same_cycle();
      test_back_to_back_reset();
      test_multi_port();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
